// File: rtl/lru_refill_arb.sv
// lru_refill_arb: round-robin arbiter that funnels cache-way refill requests
// into a single AXI4 read burst at a time and steers the returned beats back
// to the granted requester.
// Optional feature: define LRU_REFILL_ARB_PERF_EN to add the perf_grants
// output with one wrapping 32-bit grant counter per requester.
module lru_refill_arb #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_WIDTH  = 48,
    parameter int DATA_WIDTH  = 512,
    parameter int BURST_BEATS = 1
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_last,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic                          m_arvalid,
    input  logic                          m_arready,
    output logic [ADDR_WIDTH-1:0]         m_araddr,
    output logic [7:0]                    m_arlen,
    input  logic                          m_rvalid,
    output logic                          m_rready,
    input  logic [DATA_WIDTH-1:0]         m_rdata,
    input  logic                          m_rlast,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          err_rlast
`ifdef LRU_REFILL_ARB_PERF_EN
    ,
    output logic [NUM_REQ*32-1:0]         perf_grants
`endif
);

    localparam int IDW      = $clog2(NUM_REQ);
    localparam int OFF_BITS = $clog2(BURST_BEATS * DATA_WIDTH / 8);
    localparam int CNTW     = 6;
    // Burst-aligned address: clear the byte offset covered by one whole burst.
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
        ~((ADDR_WIDTH'(1) << OFF_BITS) - ADDR_WIDTH'(1));
    localparam logic [7:0]      ARLEN    = 8'(BURST_BEATS - 1);
    localparam logic [CNTW-1:0] LAST_IDX = CNTW'(BURST_BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10
    } state_t;

    state_t                r_state;
    logic [IDW-1:0]        r_grant_id;
    logic [IDW-1:0]        r_rr_ptr;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [7:0]            r_arlen;
    logic                  r_arvalid;
    logic                  r_busy;
    logic [CNTW-1:0]       r_beat_cnt;
    logic                  r_err_rlast;

    logic                  w_found;
    logic [IDW-1:0]        w_sel;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [NUM_REQ-1:0]    w_grant_vec;
    logic                  w_hs;
    logic                  w_is_last_idx;
    int                    w_idx;

    // Round-robin pick: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        w_found    = 1'b0;
        w_sel      = '0;
        w_sel_addr = '0;
        w_idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (int'(r_rr_ptr) + k >= NUM_REQ) ? int'(r_rr_ptr) + k - NUM_REQ
                                                     : int'(r_rr_ptr) + k;
            if (!w_found && req_valid[w_idx]) begin
                w_found    = 1'b1;
                w_sel      = IDW'(w_idx);
                w_sel_addr = req_addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
            end else begin
                w_found    = w_found;
            end
        end
    end

    assign w_grant_vec   = w_found ? (NUM_REQ'(1) << w_sel) : '0;
    assign w_hs          = (r_state == ST_DATA) && m_rvalid && m_rready;
    assign w_is_last_idx = (r_beat_cnt == LAST_IDX);

    // Grant strobe in IDLE and combinational R-channel steering in DATA.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        rsp_data  = '0;
        rsp_last  = 1'b0;
        m_rready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // rstn gating keeps the strobe low while reset is held.
                req_ready = rstn ? w_grant_vec : '0;
            end
            ST_DATA: begin
                rsp_valid = NUM_REQ'(m_rvalid) << r_grant_id;
                rsp_data  = m_rdata;
                rsp_last  = m_rlast;
                m_rready  = rsp_ready[r_grant_id];
            end
            default: begin
                req_ready = '0;
            end
        endcase
    end

    // Burst sequencer: grant, issue AR, count R beats, track rlast errors.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_grant_id  <= '0;
            r_rr_ptr    <= '0;
            r_araddr    <= '0;
            r_arlen     <= 8'd0;
            r_arvalid   <= 1'b0;
            r_busy      <= 1'b0;
            r_beat_cnt  <= '0;
            r_err_rlast <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state    <= ST_ADDR;
                        r_grant_id <= w_sel;
                        r_araddr   <= w_sel_addr & ADDR_MASK;
                        r_arlen    <= ARLEN;
                        r_arvalid  <= 1'b1;
                        r_busy     <= 1'b1;
                        r_beat_cnt <= '0;
                    end
                end
                ST_ADDR: begin
                    if (m_arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_hs) begin
                        // rlast must coincide exactly with the final counted beat.
                        if (m_rlast != w_is_last_idx) begin
                            r_err_rlast <= 1'b1;
                        end
                        if (m_rlast) begin
                            r_state    <= ST_IDLE;
                            r_busy     <= 1'b0;
                            r_beat_cnt <= '0;
                            r_rr_ptr   <= (r_grant_id == IDW'(NUM_REQ - 1)) ? '0
                                                                           : r_grant_id + IDW'(1);
                        end else begin
                            // Saturate so an overlong burst never aliases back onto LAST_IDX.
                            r_beat_cnt <= (r_beat_cnt == '1) ? r_beat_cnt
                                                              : r_beat_cnt + CNTW'(1);
                        end
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_arvalid <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign m_arvalid = r_arvalid;
    assign m_araddr  = r_araddr;
    assign m_arlen   = r_arlen;
    assign busy      = r_busy;
    assign grant_id  = r_grant_id;
    assign err_rlast = r_err_rlast;

`ifdef LRU_REFILL_ARB_PERF_EN
    logic [NUM_REQ*32-1:0] r_perf;

    // Per-requester grant counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_perf <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if ((r_state == ST_IDLE) && w_found && (w_sel == IDW'(i))) begin
                    r_perf[i*32 +: 32] <= r_perf[i*32 +: 32] + 32'd1;
                end
            end
        end
    end

    assign perf_grants = r_perf;
`endif

endmodule

// File: tb/tb_lru_refill_arb.sv
// Self-checking bench for lru_refill_arb: a behavioural reference model checked
// every cycle, directed scenarios with literal expectations, and random traffic.
module tb_lru_refill_arb;

    logic         clk = 1'b0;
    logic         rstn;
    logic [3:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [191:0] req_addr;
    logic [63:0]  rsp_data, m_rdata;
    logic         rsp_last, m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
    logic         busy, err_rlast;
    logic [47:0]  m_araddr;
    logic [7:0]   m_arlen;
    logic [1:0]   grant_id;

    logic [3:0]   d1_req_valid, d1_req_ready, d1_rsp_valid, d1_rsp_ready;
    logic [191:0] d1_req_addr;
    logic [511:0] d1_rsp_data, d1_m_rdata;
    logic         d1_rsp_last, d1_m_arvalid, d1_m_arready, d1_m_rvalid, d1_m_rready, d1_m_rlast;
    logic         d1_busy, d1_err;
    logic [47:0]  d1_m_araddr;
    logic [7:0]   d1_m_arlen;
    logic [1:0]   d1_grant_id;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lru_refill_arb #(.NUM_REQ(4), .ADDR_WIDTH(48), .DATA_WIDTH(64), .BURST_BEATS(4)) u_dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .rsp_ready(rsp_ready), .m_arvalid(m_arvalid),
        .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
        .m_rlast(m_rlast), .busy(busy), .grant_id(grant_id), .err_rlast(err_rlast)
    );

    lru_refill_arb #(.NUM_REQ(4), .ADDR_WIDTH(48), .DATA_WIDTH(512), .BURST_BEATS(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .req_valid(d1_req_valid), .req_addr(d1_req_addr),
        .req_ready(d1_req_ready), .rsp_valid(d1_rsp_valid), .rsp_data(d1_rsp_data),
        .rsp_last(d1_rsp_last), .rsp_ready(d1_rsp_ready), .m_arvalid(d1_m_arvalid),
        .m_arready(d1_m_arready), .m_araddr(d1_m_araddr), .m_arlen(d1_m_arlen),
        .m_rvalid(d1_m_rvalid), .m_rready(d1_m_rready), .m_rdata(d1_m_rdata),
        .m_rlast(d1_m_rlast), .busy(d1_busy), .grant_id(d1_grant_id), .err_rlast(d1_err)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int oh_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    // ---------------- reference model (checked on every falling edge) ----------
    int          m_st, m_id, m_ptr, m_cnt, m_sel;
    logic        m_any, m_err;
    logic [47:0] m_addr;

    initial begin
        m_st = 0; m_id = 0; m_ptr = 0; m_cnt = 0; m_err = 1'b0; m_addr = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                chk("rst_req_ready", 64'(req_ready), 64'h0);
                chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
                chk("rst_rsp_data",  rsp_data, 64'h0);
                chk("rst_rsp_last",  64'(rsp_last), 64'h0);
                chk("rst_arvalid",   64'(m_arvalid), 64'h0);
                chk("rst_araddr",    64'(m_araddr), 64'h0);
                chk("rst_arlen",     64'(m_arlen), 64'h0);
                chk("rst_rready",    64'(m_rready), 64'h0);
                chk("rst_busy",      64'(busy), 64'h0);
                chk("rst_grant_id",  64'(grant_id), 64'h0);
                chk("rst_err",       64'(err_rlast), 64'h0);
                m_st = 0; m_id = 0; m_ptr = 0; m_cnt = 0; m_err = 1'b0;
            end else begin
                m_any = 1'b0; m_sel = 0;
                for (int k = 0; k < 4; k++) begin
                    if (!m_any && req_valid[(m_ptr + k) % 4]) begin
                        m_any = 1'b1; m_sel = (m_ptr + k) % 4;
                    end
                end
                chk("err_rlast", 64'(err_rlast), 64'(m_err));
                case (m_st)
                    0: begin
                        chk("idle_req_ready", 64'(req_ready), m_any ? (64'h1 << m_sel) : 64'h0);
                        chk("idle_busy",      64'(busy), 64'h0);
                        chk("idle_arvalid",   64'(m_arvalid), 64'h0);
                        chk("idle_rsp_valid", 64'(rsp_valid), 64'h0);
                        chk("idle_rready",    64'(m_rready), 64'h0);
                    end
                    1: begin
                        chk("addr_req_ready", 64'(req_ready), 64'h0);
                        chk("addr_arvalid",   64'(m_arvalid), 64'h1);
                        chk("addr_araddr",    64'(m_araddr), 64'(m_addr & ~48'h1F));
                        chk("addr_arlen",     64'(m_arlen), 64'd3);
                        chk("addr_busy",      64'(busy), 64'h1);
                        chk("addr_grant_id",  64'(grant_id), 64'(m_id));
                        chk("addr_rsp_valid", 64'(rsp_valid), 64'h0);
                        chk("addr_rready",    64'(m_rready), 64'h0);
                    end
                    default: begin
                        chk("data_req_ready", 64'(req_ready), 64'h0);
                        chk("data_arvalid",   64'(m_arvalid), 64'h0);
                        chk("data_busy",      64'(busy), 64'h1);
                        chk("data_grant_id",  64'(grant_id), 64'(m_id));
                        chk("data_rsp_valid", 64'(rsp_valid), m_rvalid ? (64'h1 << m_id) : 64'h0);
                        chk("data_rready",    64'(m_rready), 64'(rsp_ready[m_id]));
                        if (m_rvalid) begin
                            chk("data_rsp_data", rsp_data, m_rdata);
                            chk("data_rsp_last", 64'(rsp_last), 64'(m_rlast));
                        end
                    end
                endcase
                // advance model with the inputs the next rising edge will see
                case (m_st)
                    0: if (m_any) begin
                        m_st = 1; m_id = m_sel; m_addr = req_addr[m_sel*48 +: 48];
                    end
                    1: if (m_arready) begin m_st = 2; m_cnt = 0; end
                    default: if (m_rvalid && rsp_ready[m_id]) begin
                        m_cnt++;
                        if (m_rlast != (m_cnt == 4)) m_err = 1'b1;
                        if (m_rlast) begin m_st = 0; m_ptr = (m_id + 1) % 4; end
                    end
                endcase
            end
        end
    end

    // ---------------- stimulus ---------------------------------------------------
    int   bk_beats, bk_last_at;
    logic rand_last;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // One cycle: backend rlast from beat count, sample outputs, cross the edge.
    task automatic cyc(output logic [3:0] rr_o, output logic hs_o,
                       output logic [63:0] d_o, output logic l_o);
        logic lst;
        m_rlast = (bk_beats + 1 == bk_last_at);
        #1;
        rr_o = req_ready; hs_o = m_rvalid && m_rready; d_o = rsp_data; l_o = rsp_last;
        lst  = m_rlast;
        @(posedge clk); #1;
        if (hs_o) begin
            if (lst) begin
                bk_beats = 0;
                if (rand_last) bk_last_at = ($urandom % 8 == 0) ? int'($urandom_range(1, 6)) : 4;
            end else begin
                bk_beats++;
            end
        end
    endtask

    logic [3:0]  s_rr;
    logic        s_hs, s_l;
    logic [63:0] s_d;

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 60 && busy; i++) cyc(s_rr, s_hs, s_d, s_l);
        chk(nm, 64'(busy), 64'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] got[$];
        logic        lasts[$];
        int          ng, nb;

        rstn = 1'b0; req_valid = 4'hF; req_addr = '0; rsp_ready = '0;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rlast = 1'b0;
        d1_req_valid = '0; d1_req_addr = '0; d1_rsp_ready = '0; d1_m_arready = 1'b0;
        d1_m_rvalid = 1'b0; d1_m_rdata = '0; d1_m_rlast = 1'b0;
        bk_beats = 0; bk_last_at = 4; rand_last = 1'b0;
        tick(); tick();
        #1;
        chk("reset_req_ready_gated", 64'(req_ready), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_d1_req_ready", 64'(d1_req_ready), 64'h0);
        req_valid = 4'h0; rstn = 1'b1;
        tick();

        // single request on the 1-beat, 512-bit instance
        d1_req_addr[2*48 +: 48] = 48'h1234_5678_9ABC;
        d1_req_valid = 4'b0100;
        #1 chk("single_req_ready", 64'(d1_req_ready), 64'h4);
        tick();
        chk("single_req_ready_once", 64'(d1_req_ready), 64'h0);
        chk("single_arvalid", 64'(d1_m_arvalid), 64'h1);
        chk("single_araddr", 64'(d1_m_araddr), 64'h1234_5678_9A80);
        chk("single_arlen", 64'(d1_m_arlen), 64'h0);
        chk("single_grant_id", 64'(d1_grant_id), 64'h2);
        d1_req_valid = 4'b0; d1_m_arready = 1'b1;
        tick();
        d1_m_arready = 1'b0; d1_m_rvalid = 1'b1; d1_m_rlast = 1'b1;
        d1_m_rdata = {8{64'hA5A5_0000_0000_0001}}; d1_rsp_ready = 4'b0100;
        #1;
        chk("single_rsp_valid", 64'(d1_rsp_valid), 64'h4);
        chk("single_rsp_last", 64'(d1_rsp_last), 64'h1);
        chk("single_rsp_data", d1_rsp_data[63:0], 64'hA5A5_0000_0000_0001);
        tick();
        d1_m_rvalid = 1'b0; d1_m_rlast = 1'b0;
        #1;
        chk("single_done_busy", 64'(d1_busy), 64'h0);
        chk("single_err", 64'(d1_err), 64'h0);

        // fairness: everyone asking, 8 bursts
        req_valid = 4'hF; req_addr = {6{$urandom}}; m_arready = 1'b1; m_rvalid = 1'b1; rsp_ready = 4'hF;
        ng = 0;
        for (int g = 0; g < 200 && ng < 8; g++) begin
            m_rdata = {$urandom, $urandom};
            cyc(s_rr, s_hs, s_d, s_l);
            if (s_rr != 4'h0) begin
                chk($sformatf("fair_grant%0d", ng), 64'(oh_idx(s_rr)), 64'(ng % 4));
                ng++;
            end
        end
        chk("fair_grant_count", 64'(ng), 64'd8);
        req_valid = 4'h0;
        wait_idle("fair_idle");

        // backpressure: AR stalled 5 cycles, then gappy R with toggling rsp_ready
        req_addr[48 +: 48] = 48'hABCD_EF01_2345;
        req_valid = 4'b0010; m_arready = 1'b0; m_rvalid = 1'b0; rsp_ready = 4'h0;
        cyc(s_rr, s_hs, s_d, s_l);
        chk("bp_grant", 64'(s_rr), 64'h2);
        req_valid = 4'h0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_arvalid", 64'(m_arvalid), 64'h1);
            chk("bp_araddr", 64'(m_araddr), 64'hABCD_EF01_2340);
            chk("bp_arlen", 64'(m_arlen), 64'd3);
            cyc(s_rr, s_hs, s_d, s_l);
        end
        m_arready = 1'b1;
        cyc(s_rr, s_hs, s_d, s_l);
        m_arready = 1'b0;
        for (int i = 0; i < 40 && busy; i++) begin
            rsp_ready = (i % 2 == 1) ? 4'b0010 : 4'b0000;
            m_rvalid  = (i % 3 != 2);
            m_rdata   = 64'h100 + 64'(bk_beats);
            cyc(s_rr, s_hs, s_d, s_l);
            if (s_hs) begin got.push_back(s_d); lasts.push_back(s_l); end
        end
        chk("bp_beats", 64'(got.size()), 64'd4);
        for (int i = 0; i < got.size(); i++) begin
            chk($sformatf("bp_data%0d", i), got[i], 64'h100 + 64'(i));
            chk($sformatf("bp_last%0d", i), 64'(lasts[i]), 64'(i == 3));
        end
        chk("bp_busy_end", 64'(busy), 64'h0);
        chk("bp_err", 64'(err_rlast), 64'h0);

        // protocol error: rlast on beat 2 of 4
        bk_last_at = 2;
        req_valid = 4'b0001; m_arready = 1'b1; m_rvalid = 1'b1; rsp_ready = 4'hF;
        cyc(s_rr, s_hs, s_d, s_l);
        chk("perr_grant", 64'(s_rr), 64'h1);
        req_valid = 4'h0;
        nb = 0;
        for (int i = 0; i < 20 && nb < 2; i++) begin
            cyc(s_rr, s_hs, s_d, s_l);
            if (s_hs) begin
                nb++;
                chk($sformatf("perr_busy_beat%0d", nb), 64'(busy), 64'(nb < 2));
                chk($sformatf("perr_err_beat%0d", nb), 64'(err_rlast), 64'(nb == 2));
            end
        end
        chk("perr_beats", 64'(nb), 64'd2);
        bk_last_at = 4;

        // reset while in DATA after one beat
        req_valid = 4'b1000;
        cyc(s_rr, s_hs, s_d, s_l);
        chk("rst_test_grant", 64'(s_rr), 64'h8);
        req_valid = 4'h0;
        cyc(s_rr, s_hs, s_d, s_l);
        cyc(s_rr, s_hs, s_d, s_l);
        chk("rst_test_beat1", 64'(s_hs), 64'h1);
        req_valid = 4'b1001;
        rstn = 1'b0; bk_beats = 0;
        #1;
        chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_mid_rready", 64'(m_rready), 64'h0);
        chk("rst_mid_busy", 64'(busy), 64'h0);
        chk("rst_mid_err", 64'(err_rlast), 64'h0);
        tick();
        rstn = 1'b1;
        #1 chk("rst_next_grant_lowest", 64'(req_ready), 64'h1);
        cyc(s_rr, s_hs, s_d, s_l);
        req_valid = 4'h0;
        wait_idle("rst_follow_idle");

        // randomized traffic with occasional rlast faults and resets
        rand_last = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            req_valid = ($urandom % 4 != 0) ? 4'($urandom) : 4'h0;
            req_addr  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            m_arready = ($urandom % 3 != 0);
            m_rvalid  = ($urandom % 4 != 0);
            rsp_ready = 4'($urandom);
            m_rdata   = {$urandom, $urandom};
            if ($urandom % 700 == 0) begin
                rstn = 1'b0; bk_beats = 0;
                tick();
                rstn = 1'b1;
            end
            cyc(s_rr, s_hs, s_d, s_l);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
